// File: rtl/mod107_pkg.sv
// Shared constants and state type for the mod-107 residue path (LUT stage,
// accumulator and downstream residue-domain blocks).
package mod107_pkg;

    localparam int unsigned MODULUS    = 107;
    localparam int unsigned RES_W      = 7;
    localparam int unsigned NUM_CHUNKS = 67;
    localparam int unsigned CNT_W      = $clog2(NUM_CHUNKS);

    typedef enum logic [0:0] {
        ACCUM,
        DONE
    } state_e;

endpackage

// File: rtl/mod107_add.sv
// Combinational (a + b) mod MODULUS for reduced operands a, b < MODULUS.
module mod107_add
    import mod107_pkg::*;
(
    input  logic [RES_W-1:0] a_i,
    input  logic [RES_W-1:0] b_i,
    output logic [RES_W-1:0] sum_o
);

    localparam logic [RES_W:0] ModExt = (RES_W + 1)'(MODULUS);

    logic [RES_W:0] sum_full;
    logic [RES_W:0] sum_red;

    // Sum of two reduced operands is below 2*MODULUS, so one subtract suffices.
    always_comb begin
        sum_full = {1'b0, a_i} + {1'b0, b_i};
        sum_red  = (sum_full >= ModExt) ? (sum_full - ModExt) : sum_full;
        sum_o    = sum_red[RES_W-1:0];
    end

endmodule

// File: rtl/mod107_residue_accum.sv
// Accumulates NUM_CHUNKS partial residues modulo MODULUS per operand and
// presents the final residue plus an out-of-range flag through valid/ready.
module mod107_residue_accum
    import mod107_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [RES_W-1:0] in_res_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [RES_W-1:0] out_res_o,
    output logic             out_err_o
);

    localparam logic [RES_W-1:0] ModRes  = RES_W'(MODULUS);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(NUM_CHUNKS - 1);

    state_e           state_q, state_d;
    logic [RES_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic             in_ge;
    logic [RES_W-1:0] in_red;
    logic [RES_W-1:0] acc_sum;

    // Illegal partials (>= MODULUS) are folded back once and flagged.
    always_comb begin
        in_ge  = (in_res_i >= ModRes);
        in_red = in_ge ? (in_res_i - ModRes) : in_res_i;
    end

    mod107_add u_add (
        .a_i   (acc_q),
        .b_i   (in_red),
        .sum_o (acc_sum)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            ACCUM: begin
                if (in_valid_i) begin
                    acc_d = acc_sum;
                    err_d = err_q | in_ge;
                    if (cnt_q == CntLast) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    err_d   = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        in_ready_o  = (state_q == ACCUM);
        out_valid_o = (state_q == DONE);
        out_res_o   = acc_q;
        out_err_o   = err_q;
    end

endmodule

// File: tb/tb_mod107_residue_accum.sv
// Directed bench for mod107_residue_accum: fixed frames, stall, async reset
// and randomly gapped frames checked against a running integer sum.
module tb_mod107_residue_accum;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] in_res;
    logic       out_valid;
    logic       out_ready;
    logic [6:0] out_res;
    logic       out_err;

    int n_checks = 0;
    int n_pass   = 0;

    mod107_residue_accum dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_res_i    (in_res),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_res_o   (out_res),
        .out_err_o   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Presents one chunk after 'gap' idle cycles; returns at the negedge after acceptance.
    task automatic send_chunk(input logic [6:0] v, input int gap);
        int n;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_res   = v;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("accept_timeout", 32'd0, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic finish_frame(input string tag, input logic [6:0] exp_res, input logic exp_err);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_res"}, 32'(out_res), 32'(exp_res));
        check({tag, "_err"}, 32'(out_err), 32'(exp_err));
        check({tag, "_inrdy"}, 32'(in_ready), 32'd0);
        if (out_ready) begin
            @(negedge clk);
            check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
            check({tag, "_inrdy_back"}, 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        logic [6:0] v;
        int         sum;
        logic [6:0] held_res;
        logic       held_err;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_res    = '0;
        out_ready = 1'b1;
        #2;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_res", 32'(out_res), 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // All zeros, back-to-back.
        for (int i = 0; i < 67; i++) begin
            send_chunk(7'd0, 0);
            if (i < 66) check("zeros_no_early_valid", 32'(out_valid), 32'd0);
        end
        finish_frame("zeros", 7'd0, 1'b0);

        // 67 * 106 = 7102 = 66*107 + 40.
        for (int i = 0; i < 67; i++) send_chunk(7'd106, 0);
        finish_frame("all106", 7'd40, 1'b0);

        for (int i = 0; i < 67; i++) send_chunk(7'd1, 0);
        finish_frame("all1", 7'd67, 1'b0);

        // 120 folds to 13 and flags the frame.
        send_chunk(7'd120, 0);
        for (int i = 1; i < 67; i++) send_chunk(7'd0, 0);
        finish_frame("illegal120", 7'd13, 1'b1);

        for (int i = 0; i < 67; i++) send_chunk(7'd0, 0);
        finish_frame("err_cleared", 7'd0, 1'b0);

        // 127 folds to 20.
        send_chunk(7'd127, 0);
        for (int i = 1; i < 67; i++) send_chunk(7'd0, 0);
        finish_frame("illegal127", 7'd20, 1'b1);

        // Output stall: 67 * 2 = 134 -> 27; next chunk held on in_valid meanwhile.
        out_ready = 1'b0;
        for (int i = 0; i < 67; i++) send_chunk(7'd2, 0);
        finish_frame("stall", 7'd27, 1'b0);
        in_valid = 1'b1;
        in_res   = 7'd5;
        held_res = out_res;
        held_err = out_err;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_res", 32'(out_res), 32'(held_res));
            check("stall_err", 32'(out_err), 32'(held_err));
            check("stall_inrdy", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("stall_release_valid", 32'(out_valid), 32'd0);
        check("stall_release_acc", 32'(out_res), 32'd0);
        check("stall_release_inrdy", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("held_chunk_acc", 32'(out_res), 32'd5);
        for (int i = 1; i < 67; i++) send_chunk(7'd0, 0);
        finish_frame("after_stall", 7'd5, 1'b0);

        // Asynchronous reset mid-frame.
        for (int i = 0; i < 30; i++) send_chunk(7'd1, 0);
        check("pre_rst_acc", 32'(out_res), 32'd30);
        #2 rst = 1'b1;
        #1;
        check("async_rst_res", 32'(out_res), 32'd0);
        check("async_rst_inrdy", 32'(in_ready), 32'd1);
        check("async_rst_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 67; i++) begin
            send_chunk(7'd1, 0);
            if (i == 65) check("post_rst_no_early_valid", 32'(out_valid), 32'd0);
        end
        finish_frame("post_rst", 7'd67, 1'b0);

        // Random legal partials with ~50% idle gaps.
        for (int f = 0; f < 200; f++) begin
            sum = 0;
            for (int i = 0; i < 67; i++) begin
                v = 7'($urandom_range(0, 106));
                sum += int'(v);
                send_chunk(v, int'($urandom_range(0, 1)));
            end
            finish_frame("random", 7'(sum % 107), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
